core_debug_scanner: RTL
=======================

Name: core_debug_scanner

Overview:
- Debug front-end directly upstream of RV32core. Drives its debug_en, debug_step and debug_addr inputs, and consumes debug_data.
- Converts a level step request into a single-cycle core step.
- Sweeps the core's debug address space and streams (address, data) pairs to a display/UART consumer over a valid/ready handshake.

Parameters:
- NUM_ENTRIES, 128: number of debug addresses swept, 0..NUM_ENTRIES-1. Legal range 1..128.
- RD_LAT, 1: cycles from a stable debug_addr to valid debug_data. Legal range 0..3.
- AUTO_SCAN, 1: when 1, every accepted step is followed automatically by a full scan.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- dbg_en_i  in  1  debug mode switch
- step_req  in  1  step request level (debounced button/switch)
- start  in  1  scan request pulse or level
- debug_en  out  1  to core debug_en; equals dbg_en_i (combinational)
- debug_step  out  1  to core debug_step; one-cycle pulse
- debug_addr  out  7  to core debug_addr; registered
- debug_data  in  32  from core debug_data
- out_valid  out  1  output pair valid
- out_ready  in  1  consumer ready
- out_addr  out  7  address of the current pair
- out_data  out  32  captured data of the current pair
- busy  out  1  high in CAPT and SEND
- done  out  1  one-cycle pulse when a scan completes

Behaviour:
- Reset values: debug_step=0, debug_addr=0, out_valid=0, out_addr=0, out_data=0, busy=0, done=0, state=IDLE, lat_cnt=0, step_q=0.
- Reset mid-scan aborts the scan; no partial done pulse.
- step_q registers step_req every cycle. A rising edge is step_req=1 and step_q=0.
- States: IDLE, STEP, CAPT, SEND.
- IDLE, step edge with dbg_en_i=1: go to STEP. A step edge takes priority over start in the same cycle.
- IDLE, start=1 otherwise: go to CAPT with debug_addr=0 and lat_cnt=0.
- STEP: debug_step=1 for exactly this cycle.
  - AUTO_SCAN=1: next state is CAPT with debug_addr=0.
  - AUTO_SCAN=0: next state is IDLE.
- Step edges with dbg_en_i=0 are ignored.
- Step edges and start outside IDLE are dropped, not queued. A level start still high on return to IDLE starts a new scan.
- CAPT: lat_cnt increments each cycle. When lat_cnt==RD_LAT:
  - out_data <= debug_data
  - out_addr <= debug_addr
  - out_valid <= 1
  - go to SEND
- debug_addr is stable throughout CAPT and SEND.
- SEND: out_valid, out_addr and out_data are held constant until out_valid and out_ready are both high (handshake).
- On handshake, out_valid <= 0, then:
  - debug_addr != NUM_ENTRIES-1: debug_addr increments, lat_cnt <= 0, go to CAPT.
  - debug_addr == NUM_ENTRIES-1: debug_addr <= 0, done=1 on the next cycle, go to IDLE.
- Throughput with out_ready held high: one pair per RD_LAT+2 cycles.
- Full scan length, first CAPT cycle to done: NUM_ENTRIES*(RD_LAT+2) cycles. Defaults give 384.
- debug_addr never exceeds NUM_ENTRIES-1; there is no wrap within a scan.
- NUM_ENTRIES=1 gives a single-pair scan.
- out_ready low stalls indefinitely without data loss. out_ready high outside SEND has no effect.
- dbg_en_i falling during a scan does not abort the scan.
- busy is a combinational decode of state.

Test Plan:
- Reset, then start=1 for 1 cycle, defaults, out_ready=1, debug_data=addr*4 -> 128 pairs; pair k has out_addr=k and out_data=4k; pairs 3 cycles apart; done 384 cycles after the first CAPT; debug_addr=0 afterwards.
- dbg_en_i=1, step_req held high for 10 cycles, AUTO_SCAN=1 -> exactly one debug_step pulse, then a full scan; step_req re-toggled during the scan -> no additional pulse.
- dbg_en_i=0, step_req toggled -> debug_step stays 0, state stays IDLE; debug_en=0.
- out_ready low for 5 cycles while pair 7 is valid -> out_addr=7 and out_data held constant, debug_addr=7 unchanged; pair 8 follows 3 cycles after out_ready rises.
- rst asserted at pair 50 -> next cycle out_valid=0, busy=0, debug_addr=0, done never pulses; a fresh start restarts the scan from address 0.
- NUM_ENTRIES=1, RD_LAT=0 -> exactly 1 pair (addr 0); done 2 cycles after the CAPT entry. Also check start and step edge in the same cycle -> STEP is taken first, then exactly one scan.

Source files
------------

// File: rtl/core_debug_scanner.sv
// Debug front-end for RV32core: turns a step level into a one-cycle core step and sweeps debug_addr, streaming (addr, data) pairs.
// Latency: a pair is offered RD_LAT+1 cycles after its address is driven; one pair per RD_LAT+2 cycles when out_ready stays high.
// Backpressure: out_ready low holds the current pair and debug_addr indefinitely; step/start requests outside IDLE are dropped.
module core_debug_scanner #(
  parameter int NUM_ENTRIES = 128,
  parameter int RD_LAT      = 1,
  parameter bit AUTO_SCAN   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dbg_en_i,
  input  logic        step_req,
  input  logic        start,
  output logic        debug_en,
  output logic        debug_step,
  output logic [6:0]  debug_addr,
  input  logic [31:0] debug_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [6:0]  out_addr,
  output logic [31:0] out_data,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, STEP, CAPT, SEND} state_t;

  localparam logic [6:0] LAST_ADDR = 7'(NUM_ENTRIES - 1);
  localparam logic [1:0] LAT_END   = 2'(RD_LAT);

  state_t     state;
  state_t     state_nxt;
  logic       step_q;
  logic [1:0] lat_cnt;
  logic       step_edge;
  logic       cap_hit;
  logic       hs;
  logic       last;

  // Core debug mode follows the switch directly.
  assign debug_en  = dbg_en_i;
  assign step_edge = step_req & ~step_q;
  // Core read data is trusted once the address has been stable RD_LAT cycles.
  assign cap_hit   = (state == CAPT) && (lat_cnt == LAT_END);
  assign hs        = (state == SEND) && out_valid && out_ready;
  assign last      = (debug_addr == LAST_ADDR);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode plus the state-decoded outputs (step pulse, busy).
  always_comb begin
    state_nxt  = state;
    debug_step = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        // A step edge wins over a simultaneous scan request.
        if (step_edge && dbg_en_i) state_nxt = STEP;
        else if (start)            state_nxt = CAPT;
      end
      STEP: begin
        debug_step = 1'b1;
        state_nxt  = AUTO_SCAN ? CAPT : IDLE;
      end
      CAPT: begin
        busy = 1'b1;
        if (cap_hit) state_nxt = SEND;
      end
      SEND: begin
        busy = 1'b1;
        if (hs) state_nxt = last ? IDLE : CAPT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: step edge history, read-latency counter, address sweep, output pair and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_q     <= 1'b0;
      lat_cnt    <= 2'd0;
      debug_addr <= 7'd0;
      out_valid  <= 1'b0;
      out_addr   <= 7'd0;
      out_data   <= 32'd0;
      done       <= 1'b0;
    end else begin
      step_q <= step_req;
      done   <= hs && last;
      case (state)
        IDLE, STEP: begin
          // Every scan begins at address 0 with a fresh latency count.
          lat_cnt    <= 2'd0;
          debug_addr <= 7'd0;
        end
        CAPT: begin
          lat_cnt <= lat_cnt + 2'd1;
          if (cap_hit) begin
            out_data  <= debug_data;
            out_addr  <= debug_addr;
            out_valid <= 1'b1;
          end
        end
        SEND: begin
          if (hs) begin
            out_valid  <= 1'b0;
            lat_cnt    <= 2'd0;
            debug_addr <= last ? 7'd0 : debug_addr + 7'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
